instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Fetch stage upstream of the single-cycle MIPS control unit. Owns the PC, requests instructions over a simple req/valid memory handshake, and holds each instruction in an instruction register. Presents opcode/funct/immediate fields to decode for exactly one issue window. Computes the next PC from the pc_src/jump decisions returned by control.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  instruction read request
imem_addr  out  32  word-aligned read address (= pc)
imem_rdata  in  32  instruction word, valid when imem_valid=1
imem_valid  in  1  read data valid; sampled only in FETCH
stall  in  1  hold current instruction in ISSUE
pc_src  in  1  branch taken (from control unit)
jump  in  2  00 sequential/branch, 01 j absolute, 10 jr register, 11 treated as 00
jr_target  in  32  register-file rs value for jr
instr_valid  out  1  ir holds a live instruction this cycle (ISSUE)
operation  out  6  ir[31:26]
func  out  6  ir[5:0]
instr  out  32  full ir, for register-file addressing and immediates
pc  out  32  address of the instruction in ir
pc_plus4  out  32  pc + 4
retired  out  32  count of instructions leaving ISSUE; wraps mod 2^32
fetch_err  out  1  sticky misaligned-target error

Behaviour:
- Single clock, async active-low reset: pc=RESET_PC, ir=0, retired=0, fetch_err=0, state=FETCH. While rst_n=0: imem_req=0 and instr_valid=0. Reset asserted mid-transaction abandons any outstanding read, with no response tracking.
- States: FETCH, ISSUE, HALT.
- FETCH: imem_req=1, imem_addr=pc, instr_valid=0. On imem_valid=1: ir<=imem_rdata, next state ISSUE. Otherwise remain.
- ISSUE: imem_req=0, instr_valid=1, field outputs driven from ir.
  - stall=1: hold pc, ir and state. pc_src/jump are ignored.
  - stall=0: load the next PC, increment retired, and go to FETCH.
- Next PC, in priority order:
  - jump=01: {pc_plus4[31:28], ir[25:0], 2'b00}
  - jump=10: jr_target
  - pc_src=1: pc_plus4 + (sign-extended ir[15:0] << 2)
  - otherwise: pc_plus4
  - All adds are 32-bit and wrap silently.
- Misalignment: if the selected next PC has bits [1:0] != 0 (jr only), pc is not updated, fetch_err<=1, state goes to HALT, and retired still increments.
- HALT: imem_req=0, instr_valid=0. Exits only on reset.
- imem_valid outside FETCH is ignored. An imem_valid coincident with reset release is ignored.
- Throughput: minimum 2 cycles per instruction (FETCH with same-cycle valid, then ISSUE). Each memory wait cycle adds one.
- Fields operation/func/instr remain stable for the whole of ISSUE including stalls. Outside ISSUE they show the last ir value and are don't-care to consumers.

Decomposition:
- Shared package mips_pkg:
  - fetch_state_t enum {FETCH, ISSUE, HALT}
  - jump_t encodings JUMP_SEQ=2'b00, JUMP_J=2'b01, JUMP_JR=2'b10
  - OPCODE_MSB/LSB and FUNCT_MSB/LSB field constants
- One natural sub-module: next_pc_logic. It is combinational: pc, ir, pc_src, jump and jr_target in; next_pc and misaligned out.

Test Plan:
- Reset/sequential: RESET_PC=0, memory returns valid same cycle with addi words → imem_addr sequence 0,4,8 at 2-cycle spacing; retired=3 after 6 cycles.
- Memory wait states: at pc=0x10, imem_valid delayed 3 cycles → imem_req held high 4 cycles, addr stable 0x10, a single ISSUE cycle, retired +1.
- Branch: ir=beq with imm=16'hFFFE at pc=0x20, pc_src=1 → next imem_addr=0x1C. Same case with pc_src=0 → 0x24.
- Jump priority: pc=0x1000_0040, ir=j with target field 0x000_0100, jump=01, pc_src=1 simultaneously → next addr=0x1000_0400.
- jr misaligned: jump=10, jr_target=0x0000_0082 → fetch_err=1, HALT, imem_req stays 0, pc unchanged. Only rst_n low recovers, to pc=RESET_PC.
- Stall and reset: stall=1 for 5 ISSUE cycles → instr/pc/retired constant. Assert rst_n=0 mid-FETCH → imem_req drops immediately (async). After release, pc=RESET_PC and FETCH restarts.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and field constants for the MIPS fetch stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Fetch-stage sequencing states
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } fetch_state_t;

    // Jump selector from the control unit; 2'b11 behaves like JUMP_SEQ
    typedef logic [1:0] jump_t;
    localparam jump_t JUMP_SEQ = 2'b00;
    localparam jump_t JUMP_J   = 2'b01;
    localparam jump_t JUMP_JR  = 2'b10;

    // Instruction field positions
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;

    // Branch displacement: sign-extended 16-bit immediate scaled to bytes
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage : mips_pkg
`default_nettype wire

// File: rtl/next_pc_logic.sv
`default_nettype none
// ============================================================================
//  Module      : next_pc_logic
//  Description : Combinational next-PC selection (j / jr / branch / pc+4)
//                and word-alignment check of the selected target.
//  Revision    : 1.0 - initial release
// ============================================================================
module next_pc_logic
    import mips_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] ir_i,          // only the jump-target/immediate bits matter here
    input  logic        pc_src_i,
    input  logic [1:0]  jump_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] next_pc_o,
    output logic        misaligned_o
);

    logic [31:0] w_pc_plus4;

    assign w_pc_plus4 = pc_i + 32'd4;

    // Priority select: j, then jr, then taken branch, else sequential
    always_comb begin
        next_pc_o = w_pc_plus4;
        case (jump_i)
            JUMP_J:  next_pc_o = {w_pc_plus4[31:28], ir_i, 2'b00};
            JUMP_JR: next_pc_o = jr_target_i;
            default: begin
                if (pc_src_i) begin
                    next_pc_o = w_pc_plus4 + branch_offset(ir_i[15:0]);
                end
            end
        endcase
    end

    // Only jr can produce a misaligned target; the check is generic anyway
    assign misaligned_o = (next_pc_o[1:0] != 2'b00);

endmodule : next_pc_logic
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Fetch stage owning the PC and instruction register. Requests
//                a word, holds it for one issue window, then advances the PC
//                using the control unit's branch/jump decision.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000   // must be word-aligned
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        pc_src,
    input  logic [1:0]  jump,
    input  logic [31:0] jr_target,
    output logic        instr_valid,
    output logic [5:0]  operation,
    output logic [5:0]  func,
    output logic [31:0] instr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired,
    output logic        fetch_err
);

    fetch_state_t state_q;
    logic [31:0]  pc_q;
    logic [31:0]  ir_q;
    logic [31:0]  retired_q;
    logic         fetch_err_q;

    logic [31:0]  w_next_pc;
    logic         w_misaligned;

    next_pc_logic u_next_pc (
        .pc_i         (pc_q),
        .ir_i         (ir_q[25:0]),
        .pc_src_i     (pc_src),
        .jump_i       (jump),
        .jr_target_i  (jr_target),
        .next_pc_o    (w_next_pc),
        .misaligned_o (w_misaligned)
    );

    // Fetch/issue sequencer: captures the instruction, then retires it and
    // either advances the PC or halts on a misaligned target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= 32'd0;
            retired_q   <= 32'd0;
            fetch_err_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (imem_valid) begin
                        ir_q    <= imem_rdata;
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        retired_q <= retired_q + 32'd1;
                        if (w_misaligned) begin
                            fetch_err_q <= 1'b1;
                            state_q     <= HALT;
                        end else begin
                            pc_q    <= w_next_pc;
                            state_q <= FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= HALT;
                end
            endcase
        end
    end

    // Handshake outputs are gated by rst_n so they drop the instant reset
    // asserts, abandoning any outstanding read
    assign imem_req    = rst_n & (state_q == FETCH);
    assign instr_valid = rst_n & (state_q == ISSUE);
    assign imem_addr   = pc_q;

    assign operation = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign func      = ir_q[FUNCT_MSB:FUNCT_LSB];
    assign instr     = ir_q;
    assign pc        = pc_q;
    assign pc_plus4  = pc_q + 32'd4;
    assign retired   = retired_q;
    assign fetch_err = fetch_err_q;

endmodule : instr_fetch_unit
`default_nettype wire
